dbg_display_ctrl: RTL and testbench

//  Parametrised debug-word display controller for the dev chasis; successor to
//  the fixed two-word HEX display path. Takes NUM_WORDS live debug words from
//  the DUT and shows NUM_BANKS of them at a time on the 7-segment banks.

---
 rtl/dbg_display_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dbg_display_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_display_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_display_ctrl
//   Debug-word display controller. NUM_WORDS live debug words are shown
//   NUM_BANKS at a time on banks of active-low 7-segment digits. A pushbutton
//   (synchronised and debounced) or an auto-rotate timer steps the page. The
//   freeze mode captures a snapshot of every word and displays it instead of
//   the live words.
//
// Ports
//   dbg_clk_i     clock
//   dbg_rst_i     synchronous reset, active-high
//   dbg_words_i   live debug words, word k at [k*WORD_W +: WORD_W]
//   dbg_next_i    raw pushbutton, active-high, asynchronous to dbg_clk_i
//   dbg_mode_i    00/11 manual, 01 auto-rotate, 10 freeze
//   dbg_segs_o    active-low segments, digit d of bank b at
//                 [(b*WORD_W/4+d)*7 +: 7], bit0 = a .. bit6 = g
//   dbg_page_o    current page index
//   dbg_frozen_o  high while the snapshot is displayed
// -----------------------------------------------------------------------------
module dbg_display_ctrl #(
  parameter int WORD_W       = 16,
  parameter int NUM_WORDS    = 4,
  parameter int NUM_BANKS    = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int ROTATE_CYC   = 8,
  localparam int DIGITS      = WORD_W / 4,
  localparam int PAGES       = (NUM_WORDS + NUM_BANKS - 1) / NUM_BANKS,
  localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                          dbg_clk_i,
  input  logic                          dbg_rst_i,
  input  logic [NUM_WORDS*WORD_W-1:0]   dbg_words_i,
  input  logic                          dbg_next_i,
  input  logic [1:0]                    dbg_mode_i,
  output logic [NUM_BANKS*DIGITS*7-1:0] dbg_segs_o,
  output logic [PAGE_W-1:0]             dbg_page_o,
  output logic                          dbg_frozen_o
);

  localparam int SLOTS = PAGES * NUM_BANKS;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC);
  localparam int ROT_W = $clog2(ROTATE_CYC);

  // Active-low hex digit encoding, bit0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Registers
  logic                          sync1_q, sync2_q;
  logic                          deb_q, deb_d;
  logic [DEB_W-1:0]              deb_cnt_q, deb_cnt_d;
  logic [ROT_W-1:0]              rot_cnt_q, rot_cnt_d;
  logic [PAGE_W-1:0]             page_q, page_d;
  logic                          frozen_q, frozen_d;
  logic [NUM_WORDS*WORD_W-1:0]   snapshot_q, snapshot_d;
  logic [NUM_BANKS*DIGITS*7-1:0] segs_q, segs_d;

  // Control
  logic deb_differ, deb_accept, step, auto_mode, rot_term, advance, freeze_req;

  always_comb begin
    deb_differ = (sync2_q != deb_q);
    // The counter only runs while the synchronised level differs, so hitting
    // its terminal value means DEBOUNCE_CYC consecutive differing cycles.
    deb_accept = deb_differ && (deb_cnt_q == DEB_W'(DEBOUNCE_CYC - 1));
    deb_d      = deb_accept ? sync2_q : deb_q;
    deb_cnt_d  = (!deb_differ || deb_accept) ? '0 : deb_cnt_q + DEB_W'(1);
    step       = deb_accept && sync2_q;   // only a press, never a release

    auto_mode  = (dbg_mode_i == 2'b01);
    rot_term   = auto_mode && (rot_cnt_q == ROT_W'(ROTATE_CYC - 1));
    // A step landing on the terminal count still yields one advance.
    advance    = step || rot_term;
    rot_cnt_d  = (!auto_mode || advance) ? '0 : rot_cnt_q + ROT_W'(1);

    page_d = page_q;
    if (advance) begin
      page_d = (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
    end

    freeze_req = (dbg_mode_i == 2'b10);
    frozen_d   = freeze_req;
    // Capture only on the first freeze cycle so the snapshot stays still.
    snapshot_d = (freeze_req && !frozen_q) ? dbg_words_i : snapshot_q;
  end

  // Display source: snapshot while frozen, otherwise live words. Slots beyond
  // NUM_WORDS (last page partially filled) read as zero and are blanked below.
  logic [NUM_WORDS*WORD_W-1:0] src_words;
  logic [WORD_W-1:0]           src_arr [SLOTS];

  assign src_words = frozen_q ? snapshot_q : dbg_words_i;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_WORDS) begin : g_used
        assign src_arr[gi] = src_words[gi*WORD_W +: WORD_W];
      end else begin : g_pad
        assign src_arr[gi] = '0;
      end
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      int                slot;
      logic              bank_vis;
      logic [WORD_W-1:0] bank_word;

      assign slot     = int'(page_q) * NUM_BANKS + gi;
      assign bank_vis = (slot < NUM_WORDS);

      always_comb begin
        bank_word = '0;
        for (int s = 0; s < SLOTS; s++) begin
          if (slot == s) begin
            bank_word = src_arr[s];
          end
        end
      end

      for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit
        assign segs_d[(gi*DIGITS+gd)*7 +: 7] =
          bank_vis ? hex7(bank_word[gd*4 +: 4]) : 7'h7F;
      end
    end
  endgenerate

  always_ff @(posedge dbg_clk_i) begin
    if (dbg_rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      rot_cnt_q  <= '0;
      page_q     <= '0;
      frozen_q   <= 1'b0;
      snapshot_q <= '0;
      segs_q     <= '1;
    end else begin
      sync1_q    <= dbg_next_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      page_q     <= page_d;
      frozen_q   <= frozen_d;
      snapshot_q <= snapshot_d;
      segs_q     <= segs_d;
    end
  end

  assign dbg_segs_o   = segs_q;
  assign dbg_page_o   = page_q;
  assign dbg_frozen_o = frozen_q;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbg_display_ctrl
//   Instance A: 3 words on 2 banks (two pages, last bank of page 1 blank).
//   Instance B: 2 words on 2 banks (single page, page must stay 0).
//   A reference model runs every clock edge and pushes the expected outputs
//   into a scoreboard queue; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_dbg_display_ctrl;

  localparam int DEB = 16;
  localparam int ROT = 8;

  logic        clk;
  logic        rst;
  logic [47:0] words;
  logic        next;
  logic [1:0]  mode;
  logic [55:0] segs_a, segs_b;
  logic [0:0]  page_a, page_b;
  logic        frozen_a, frozen_b;

  dbg_display_ctrl #(
    .WORD_W(16), .NUM_WORDS(3), .NUM_BANKS(2), .DEBOUNCE_CYC(DEB), .ROTATE_CYC(ROT)
  ) dut_a (
    .dbg_clk_i(clk), .dbg_rst_i(rst), .dbg_words_i(words), .dbg_next_i(next),
    .dbg_mode_i(mode), .dbg_segs_o(segs_a), .dbg_page_o(page_a), .dbg_frozen_o(frozen_a)
  );

  dbg_display_ctrl #(
    .WORD_W(16), .NUM_WORDS(2), .NUM_BANKS(2), .DEBOUNCE_CYC(DEB), .ROTATE_CYC(ROT)
  ) dut_b (
    .dbg_clk_i(clk), .dbg_rst_i(rst), .dbg_words_i(words[31:0]), .dbg_next_i(next),
    .dbg_mode_i(mode), .dbg_segs_o(segs_b), .dbg_page_o(page_b), .dbg_frozen_o(frozen_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [55:0] segs_a;
    logic [55:0] segs_b;
    int          page;
    bit          frozen;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected digits for a page: bank b shows word page*2+b when it exists.
  function automatic logic [55:0] exp_segs(int pg, int nw, bit frz,
                                           logic [47:0] snap, logic [47:0] live);
    logic [55:0] s;
    logic [15:0] w;
    s = '1;
    for (int b = 0; b < 2; b++) begin
      int k;
      k = pg * 2 + b;
      if (k < nw) begin
        w = frz ? snap[k*16 +: 16] : live[k*16 +: 16];
        for (int d = 0; d < 4; d++) s[(b*4+d)*7 +: 7] = hex_tab[w[d*4 +: 4]];
      end
    end
    return s;
  endfunction

  // Reference model: behaviour stated as rules over time.
  initial begin : model
    int          m_page, m_run, cyc, origin;
    bit          m_frozen, m_deb, h0, h1, seen, step, term;
    logic [47:0] m_snap;
    logic [55:0] ea, eb, na, nb;
    exp_t        e;
    m_page = 0; m_run = 0; cyc = 0; origin = 0;
    m_frozen = 0; m_deb = 0; h0 = 0; h1 = 0; m_snap = '0;
    ea = '1; eb = '1;
    forever begin
      @(posedge clk);
      na = exp_segs(m_page, 3, m_frozen, m_snap, words);
      nb = exp_segs(0, 2, m_frozen, m_snap, words);
      if (rst) begin
        m_page = 0; m_run = 0; m_frozen = 0; m_deb = 0; h0 = 0; h1 = 0;
        m_snap = '0; origin = cyc + 1; ea = '1; eb = '1;
      end else begin
        // Button level seen by the debouncer is the raw sample from two edges ago.
        seen = h1; h1 = h0; h0 = next;
        step = 0;
        if (seen != m_deb) begin
          m_run++;
          if (m_run == DEB) begin
            m_deb = seen; m_run = 0; step = seen;
          end
        end else begin
          m_run = 0;
        end
        // Auto: advance ROT cycles after entering auto or after the last advance.
        term = 0;
        if (mode != 2'b01) origin = cyc + 1;
        else begin
          term = ((cyc - origin) == ROT - 1);
          if (step || term) origin = cyc + 1;
        end
        if (step || term) m_page = (m_page + 1) % 2;
        if (mode == 2'b10) begin
          if (!m_frozen) m_snap = words;
          m_frozen = 1;
        end else begin
          m_frozen = 0;
        end
        ea = na; eb = nb;
      end
      e.segs_a = ea; e.segs_b = eb; e.page = m_page; e.frozen = m_frozen;
      sb.push_back(e);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("page_a",   64'(page_a),   64'(e.page));
        check("frozen_a", 64'(frozen_a), 64'(e.frozen));
        check("segs_a",   64'(segs_a),   64'(e.segs_a));
        check("page_b",   64'(page_b),   64'd0);
        check("frozen_b", 64'(frozen_b), 64'(e.frozen));
        check("segs_b",   64'(segs_b),   64'(e.segs_b));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; next = 1'b0; mode = 2'b00; words = {$urandom, $urandom};
    // T1 reset and first display
    tick(2);
    rst = 1'b0;
    words = {16'h0F0F, 16'hBEEF, 16'h1234};
    tick(4);
    $display("T1 reset/display done checks=%0d", checks);
    // T2 short pulse ignored, long press steps page 0->1
    next = 1'b1; tick(10);
    next = 1'b0; tick(20);
    next = 1'b1; tick(20);
    next = 1'b0; tick(25);
    $display("T2 debounce done checks=%0d", checks);
    // T3 second step wraps back to page 0
    next = 1'b1; tick(20);
    next = 1'b0; tick(25);
    $display("T3 wrap/blank done checks=%0d", checks);
    // T4 auto rotate, presses at assorted offsets
    mode = 2'b01; tick(20);
    for (int i = 0; i < 8; i++) begin
      next = 1'b1; tick(20 + i);
      next = 1'b0; tick(19 + $urandom_range(0, 7));
    end
    mode = 2'b00; tick(5);
    $display("T4 auto done checks=%0d", checks);
    // T5 freeze
    words[15:0] = 16'hAAAA; tick(2);
    mode = 2'b10; tick(1);
    words[15:0] = 16'h5555; tick(6);
    next = 1'b1; tick(20);
    next = 1'b0; tick(20);
    mode = 2'b00; tick(3);
    words[15:0] = 16'h1357;
    mode = 2'b10; tick(4);
    mode = 2'b00; tick(3);
    $display("T5 freeze done checks=%0d", checks);
    // T6 reset mid-debounce and mid-rotate
    next = 1'b1; tick(12);
    rst = 1'b1; next = 1'b0; tick(1);
    rst = 1'b0; tick(30);
    mode = 2'b01; tick(5);
    rst = 1'b1; tick(2);
    rst = 1'b0; mode = 2'b00; tick(20);
    $display("T6 reset mid-op done checks=%0d", checks);
    // Randomised segments
    for (int i = 0; i < 60; i++) begin
      next  = 1'($urandom_range(0, 1));
      mode  = 2'($urandom_range(0, 3));
      words = {$urandom, $urandom};
      rst   = ($urandom_range(0, 15) == 0);
      tick($urandom_range(1, 40));
      rst   = 1'b0;
      $display("RND seg=%0d mode=%0d next=%0d checks=%0d", i, mode, next, checks);
    end
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
